mpm_port_frontend: RTL and testbench

- Per-port request/response front end that sits directly upstream of the LVT multiported memory.
- Converts PORTS independent valid/ready client request streams into the memory's registered addr/en/d port arrays.
- Captures read data mem_q a fixed READ_LATENCY later, tags nothing, and returns it in order per port through a credit-protected response FIFO with valid/ready backpressure.
- Writes are posted and produce no response.

---
 rtl/mpm_port_frontend.sv | 122 ++++++++++++
 tb/tb_mpm_port_frontend.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mpm_port_frontend.sv
// Per-port valid/ready front end for the LVT multiported memory: registered issue,
// fixed-latency read capture and a credit-protected show-ahead response FIFO per port.
module mpm_port_lane #(
  parameter int WIDTH        = 32,
  parameter int AW           = 10,
  parameter int READ_LATENCY = 1,
  parameter int RESP_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_en,
  output logic [WIDTH-1:0] mem_d,
  input  logic [WIDTH-1:0] mem_q
);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         r_occ;
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [READ_LATENCY:0] r_vld_pipe;
  logic [WIDTH-1:0]      r_fifo [RESP_DEPTH];

  logic w_acc, w_rd, w_push, w_pop, w_full;

  // Credits cover every read from acceptance until its FIFO entry is popped.
  assign req_ready  = !rst && (r_cnt < CW'(RESP_DEPTH));
  assign w_acc      = req_valid && req_ready;
  assign w_rd       = w_acc && !req_we;
  assign w_push     = r_vld_pipe[READ_LATENCY];
  assign resp_valid = (r_occ != '0);
  assign w_pop      = resp_valid && resp_ready;
  assign w_full     = (r_occ == CW'(RESP_DEPTH));
  assign resp_rdata = r_fifo[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr   <= '0;
      mem_d      <= '0;
      mem_en     <= 1'b0;
      r_vld_pipe <= '0;
      r_cnt      <= '0;
      r_occ      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      mem_en <= w_acc && req_we;
      if (w_acc) begin
        mem_addr <= req_addr;
        mem_d    <= req_wdata;
      end
      // Stage 0 is the issue cycle; stage READ_LATENCY lines up with valid mem_q.
      r_vld_pipe <= {r_vld_pipe[READ_LATENCY-1:0], w_rd};
      r_cnt      <= r_cnt + CW'(w_rd) - CW'(w_pop);
      r_occ      <= r_occ + CW'(w_push) - CW'(w_pop);
      if (w_push)
        r_wptr <= (r_wptr == PW'(RESP_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= (r_rptr == PW'(RESP_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= mem_q;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));
endmodule

module mpm_port_frontend #(
  parameter  int WIDTH        = 32,
  parameter  int DEPTH        = 1024,
  parameter  int PORTS        = 32,
  parameter  int READ_LATENCY = 1,
  parameter  int RESP_DEPTH   = 4,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0]            req_valid,
  output logic [PORTS-1:0]            req_ready,
  input  logic [PORTS-1:0]            req_we,
  input  logic [PORTS-1:0][AW-1:0]    req_addr,
  input  logic [PORTS-1:0][WIDTH-1:0] req_wdata,
  output logic [PORTS-1:0]            resp_valid,
  input  logic [PORTS-1:0]            resp_ready,
  output logic [PORTS-1:0][WIDTH-1:0] resp_rdata,
  output logic [PORTS-1:0][AW-1:0]    mem_addr,
  output logic [PORTS-1:0]            mem_en,
  output logic [PORTS-1:0][WIDTH-1:0] mem_d,
  input  logic [PORTS-1:0][WIDTH-1:0] mem_q
);
  for (genvar p = 0; p < PORTS; p++) begin : g_lane
    mpm_port_lane #(
      .WIDTH(WIDTH), .AW(AW), .READ_LATENCY(READ_LATENCY), .RESP_DEPTH(RESP_DEPTH)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[p]),
      .req_ready  (req_ready[p]),
      .req_we     (req_we[p]),
      .req_addr   (req_addr[p]),
      .req_wdata  (req_wdata[p]),
      .resp_valid (resp_valid[p]),
      .resp_ready (resp_ready[p]),
      .resp_rdata (resp_rdata[p]),
      .mem_addr   (mem_addr[p]),
      .mem_en     (mem_en[p]),
      .mem_d      (mem_d[p]),
      .mem_q      (mem_q[p])
    );
  end
endmodule

// File: tb/tb_mpm_port_frontend.sv
// Directed bench for mpm_port_frontend with a behavioural registered-read memory
// (old data on same-cycle read/write, new data on the following cycle).
module tb_mpm_port_frontend;
  localparam int P = 4, W = 32, D = 64, AW = 6;

  logic clk = 1'b0, rst, mem_clr;
  always #5 clk = ~clk;

  logic [P-1:0]         req_valid, req_ready, req_we, resp_valid, resp_ready, mem_en;
  logic [P-1:0][AW-1:0] req_addr, mem_addr;
  logic [P-1:0][W-1:0]  req_wdata, resp_rdata, mem_d, mem_q;
  logic [W-1:0]         mem [D];

  int n_chk = 0, n_fail = 0;

  mpm_port_frontend #(.WIDTH(W), .DEPTH(D), .PORTS(P), .READ_LATENCY(1), .RESP_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_d(mem_d), .mem_q(mem_q)
  );

  function automatic logic [31:0] iv(int a);
    return 32'hA000_0000 + 32'(a);
  endfunction

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < D; i++) mem[i] <= iv(i);
    end else begin
      for (int p = 0; p < P; p++) begin
        if (mem_en[p]) mem[mem_addr[p]] <= mem_d[p];
        mem_q[p] <= mem[mem_addr[p]];
      end
    end
  end

  typedef struct {
    int          p;
    logic        v, we, rr;
    logic [AW-1:0] a;
    logic [31:0] wd;
    logic        e_rdy, e_en, e_rv;
    logic [AW-1:0] e_addr;
    logic [31:0] e_rd;
  } vec_t;

  function automatic vec_t mk(int p, int v, int we, int a, logic [31:0] wd, int rr,
                              int rdy, int en, int ea, int rv, logic [31:0] rd);
    vec_t r;
    r.p = p; r.v = v[0]; r.we = we[0]; r.a = AW'(a); r.wd = wd; r.rr = rr[0];
    r.e_rdy = rdy[0]; r.e_en = en[0]; r.e_addr = AW'(ea); r.e_rv = rv[0]; r.e_rd = rd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; resp_ready = '1;
  endtask

  task automatic rd(input int p, input int a);
    req_valid[p] = 1'b1; req_we[p] = 1'b0; req_addr[p] = AW'(a); req_wdata[p] = '0;
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    req_valid[p] = 1'b1; req_we[p] = 1'b1; req_addr[p] = AW'(a); req_wdata[p] = d;
  endtask

  // Expected memory contents of the low addresses after the first scenario's write.
  function automatic logic [31:0] dv(int a);
    return (a == 5) ? 32'hDEAD_BEEF : iv(a);
  endfunction

  vec_t tbl[$];
  int   acc;

  initial begin
    // port 0: write 5 then read 5
    tbl.push_back(mk(0, 1, 1, 5, 32'hDEAD_BEEF, 1,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 5, 0,            1,  1, 1, 5, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,            1,  1, 0, 5, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,            1,  1, 0, 5, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,            1,  1, 0, 5, 1, 32'hDEAD_BEEF));
    tbl.push_back(mk(0, 0, 0, 0, 0,            1,  1, 0, 5, 0, 0));
    // port 2: streaming reads of 0..7, responses back-to-back from k=3
    for (int k = 0; k < 11; k++)
      tbl.push_back(mk(2, (k < 8) ? 1 : 0, 0, (k < 8) ? k : 0, 0, 1,
                       1, 0, (k == 0) ? 0 : ((k > 8) ? 7 : k - 1),
                       (k >= 3) ? 1 : 0, (k >= 3) ? dv(k - 3) : 32'h0));

    rst = 1'b1; mem_clr = 1'b1; idle();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    @(posedge clk); #1; rst = 1'b0; mem_clr = 1'b0;

    foreach (tbl[i]) begin
      tick(); idle();
      req_valid[tbl[i].p] = tbl[i].v; req_we[tbl[i].p] = tbl[i].we;
      req_addr[tbl[i].p] = tbl[i].a; req_wdata[tbl[i].p] = tbl[i].wd;
      resp_ready[tbl[i].p] = tbl[i].rr;
      @(negedge clk);
      chk($sformatf("vec%0d_rdy", i), 32'(req_ready[tbl[i].p]), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_en", i), 32'(mem_en[tbl[i].p]), 32'(tbl[i].e_en));
      chk($sformatf("vec%0d_addr", i), 32'(mem_addr[tbl[i].p]), 32'(tbl[i].e_addr));
      chk($sformatf("vec%0d_rv", i), 32'(resp_valid[tbl[i].p]), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk($sformatf("vec%0d_rd", i), resp_rdata[tbl[i].p], tbl[i].e_rd);
    end

    // port 1 backpressure: only RESP_DEPTH reads get in
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      tick(); idle(); resp_ready[1] = 1'b0; rd(1, 10 + acc);
      @(negedge clk);
      if (req_ready[1]) acc++;
    end
    chk("bp_accepts", 32'(acc), 32'd4);
    chk("bp_stalled", 32'(req_ready[1]), 32'h0);
    tick(); idle();
    @(negedge clk);
    chk("bp_pop_rdy", 32'(req_ready[1]), 32'h0);
    chk("bp_pop_rv", 32'(resp_valid[1]), 32'h1);
    chk("bp_rd0", resp_rdata[1], iv(10));
    tick(); idle(); resp_ready[1] = 1'b0;
    @(negedge clk);
    chk("bp_credit_back", 32'(req_ready[1]), 32'h1);
    for (int i = 1; i < 4; i++) begin
      tick(); idle();
      @(negedge clk);
      chk($sformatf("bp_rv%0d", i), 32'(resp_valid[1]), 32'h1);
      chk($sformatf("bp_rd%0d", i), resp_rdata[1], iv(10 + i));
    end
    tick(); idle();
    @(negedge clk);
    chk("bp_empty", 32'(resp_valid[1]), 32'h0);

    // cross-port: p3 writes 9, p0 reads next cycle; p1 reads while p3 rewrites
    tick(); idle(); wr(3, 9, 32'h0000_1234);
    tick(); idle(); rd(0, 9); rd(1, 9); wr(3, 9, 32'h0000_5678);
    tick(); idle();
    tick(); idle();
    @(negedge clk);
    chk("xp_p0_early", 32'(resp_valid[0]), 32'h0);
    tick(); idle();
    @(negedge clk);
    chk("xp_p0_rv", 32'(resp_valid[0]), 32'h1);
    chk("xp_p0_rd", resp_rdata[0], 32'h0000_1234);
    chk("xp_p1_old", resp_rdata[1], 32'h0000_1234);
    chk("xp_p3_norsp", 32'(resp_valid[3]), 32'h0);
    tick(); idle(); rd(0, 9);
    tick(); idle(); tick(); idle(); tick(); idle();
    @(negedge clk);
    chk("xp_p0_new", resp_rdata[0], 32'h0000_5678);

    // mixed: p0 streams writes, p1 streams reads
    for (int c = 0; c < 11; c++) begin
      tick(); idle();
      if (c < 8) begin wr(0, 20 + c, 32'hC0DE_0000 + 32'(c)); rd(1, c); end
      @(negedge clk);
      chk($sformatf("mix%0d_p0_rv", c), 32'(resp_valid[0]), 32'h0);
      chk($sformatf("mix%0d_p1_rv", c), 32'(resp_valid[1]), (c >= 3) ? 32'h1 : 32'h0);
      if (c >= 3) chk($sformatf("mix%0d_p1_rd", c), resp_rdata[1], dv(c - 3));
    end

    // reset with two reads in flight and one queued on port 0
    tick(); idle(); resp_ready[0] = 1'b0; rd(0, 0);
    tick(); idle(); resp_ready[0] = 1'b0; rd(0, 1);
    tick(); idle(); resp_ready[0] = 1'b0; rd(0, 2);
    tick(); idle(); resp_ready[0] = 1'b0;
    @(negedge clk);
    chk("rm_queued", 32'(resp_valid[0]), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("rm_rv", 32'(resp_valid[0]), 32'h0);
    chk("rm_rdy", 32'(req_ready[0]), 32'h0);
    chk("rm_addr", 32'(mem_addr[0]), 32'h0);
    chk("rm_en", 32'(mem_en), 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick(); idle();
      @(negedge clk);
      chk($sformatf("rm_stale%0d", c), 32'(resp_valid[0]), 32'h0);
    end
    tick(); idle(); rd(0, 3);
    tick(); idle(); tick(); idle();
    @(negedge clk);
    chk("rm_fresh_early", 32'(resp_valid[0]), 32'h0);
    tick(); idle();
    @(negedge clk);
    chk("rm_fresh_rv", 32'(resp_valid[0]), 32'h1);
    chk("rm_fresh_rd", resp_rdata[0], iv(3));

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
